// File: rtl/led_pattern_shifter.sv
// ============================================================================
// led_pattern_shifter
// Moves a WIDTH-bit LED pattern on divided ticks: rotate R/L, bounce, hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_pattern_shifter #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               DIV_W         = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_edge
);

  localparam logic [1:0]       c_MODE_ROR    = 2'b00;
  localparam logic [1:0]       c_MODE_ROL    = 2'b01;
  localparam logic [1:0]       c_MODE_BOUNCE = 2'b10;
  localparam logic [1:0]       c_MODE_HOLD   = 2'b11;
  localparam logic [DIV_W-1:0] c_CNT_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

  // Direction doubles as the bounce FSM state.
  typedef enum logic [0:0] {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  logic [WIDTH-1:0] r_data;
  dir_t             r_dir;
  logic [DIV_W-1:0] r_cnt;
  logic             r_step;
  logic             r_edge;

  logic [WIDTH-1:0] w_data_nxt;
  dir_t             w_dir_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_step_nxt;
  logic             w_edge_nxt;

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_lsb;
  logic             w_msb;
  logic             w_tick;

  assign w_lsb  = r_data[0];
  assign w_msb  = r_data[WIDTH-1];
  assign w_shl  = {r_data[WIDTH-2:0], 1'b0};
  assign w_shr  = {1'b0, r_data[WIDTH-1:1]};
  assign w_rol  = {r_data[WIDTH-2:0], w_msb};
  assign w_ror  = {w_lsb, r_data[WIDTH-1:1]};
  assign w_tick = i_valid && (i_mode != c_MODE_HOLD);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_data <= RESET_PATTERN;
      r_dir  <= DIR_RIGHT;
      r_cnt  <= '0;
      r_step <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_dir  <= w_dir_nxt;
      r_cnt  <= w_cnt_nxt;
      r_step <= w_step_nxt;
      r_edge <= w_edge_nxt;
    end
  end

  always_comb begin
    w_data_nxt = r_data;
    w_dir_nxt  = r_dir;
    w_cnt_nxt  = r_cnt;
    w_step_nxt = 1'b0;
    w_edge_nxt = 1'b0;

    if (i_load) begin
      w_data_nxt = i_data;
      w_cnt_nxt  = '0;
    end else if (w_tick) begin
      // >= so that lowering i_div mid-count steps at once instead of wrapping.
      if (r_cnt >= i_div) begin
        w_cnt_nxt  = '0;
        w_step_nxt = 1'b1;
        case (i_mode)
          c_MODE_ROR: begin
            w_data_nxt = w_ror;
            w_dir_nxt  = DIR_RIGHT;
            w_edge_nxt = w_lsb;
          end
          c_MODE_ROL: begin
            w_data_nxt = w_rol;
            w_dir_nxt  = DIR_LEFT;
            w_edge_nxt = w_msb;
          end
          c_MODE_BOUNCE: begin
            if (w_lsb && w_msb) begin
              w_data_nxt = r_data;
            end else if (r_dir == DIR_RIGHT) begin
              if (w_lsb) begin
                w_dir_nxt  = DIR_LEFT;
                w_data_nxt = w_shl;
                w_edge_nxt = 1'b1;
              end else begin
                w_data_nxt = w_shr;
              end
            end else begin
              if (w_msb) begin
                w_dir_nxt  = DIR_RIGHT;
                w_data_nxt = w_shr;
                w_edge_nxt = 1'b1;
              end else begin
                w_data_nxt = w_shl;
              end
            end
          end
          default: begin
            w_data_nxt = r_data;
          end
        endcase
      end else begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
      end
    end
  end

  assign o_data = r_data;
  assign o_dir  = r_dir;
  assign o_step = r_step;
  assign o_edge = r_edge;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_shifter.sv
// ============================================================================
// tb_led_pattern_shifter
// Random and directed stimulus against a reference model; WIDTH 4 and 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] mode;
  logic [3:0] div;
  logic       load;
  logic [7:0] data8;

  logic [3:0] d4;
  logic       dir4, step4, edge4;
  logic [7:0] d8;
  logic       dir8, step8, edge8;

  int n_cmp = 0;
  int n_bad = 0;

  int m_data[2];
  int m_dir[2];
  int m_cnt[2];
  int m_step[2];
  int m_edge[2];

  always #5 clk = ~clk;

  led_pattern_shifter #(.WIDTH(4), .DIV_W(4)) u_dut4 (
    .clk(clk), .i_rst(rst), .i_valid(valid), .i_mode(mode), .i_div(div),
    .i_load(load), .i_data(data8[3:0]),
    .o_data(d4), .o_dir(dir4), .o_step(step4), .o_edge(edge4)
  );

  led_pattern_shifter #(.WIDTH(8), .RESET_PATTERN(8'h81), .DIV_W(4)) u_dut8 (
    .clk(clk), .i_rst(rst), .i_valid(valid), .i_mode(mode), .i_div(div),
    .i_load(load), .i_data(data8),
    .o_data(d8), .o_dir(dir8), .o_step(step8), .o_edge(edge8)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour per instance, using plain integer arithmetic.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int w    = (k == 0) ? 4 : 8;
      int mask = (1 << w) - 1;
      int d    = m_data[k];
      int lo   = d & 1;
      int hi   = (d >> (w - 1)) & 1;
      m_step[k] = 0;
      m_edge[k] = 0;
      if (rst) begin
        m_data[k] = (k == 0) ? 1 : 'h81;
        m_dir[k]  = 0;
        m_cnt[k]  = 0;
      end else if (load) begin
        m_data[k] = int'(data8) & mask;
        m_cnt[k]  = 0;
      end else if (valid && mode != 2'd3) begin
        if (m_cnt[k] >= int'(div)) begin
          m_cnt[k]  = 0;
          m_step[k] = 1;
          if (mode == 2'd0) begin
            m_data[k] = (d >> 1) | (lo << (w - 1));
            m_dir[k]  = 0;
            m_edge[k] = lo;
          end else if (mode == 2'd1) begin
            m_data[k] = ((d << 1) & mask) | hi;
            m_dir[k]  = 1;
            m_edge[k] = hi;
          end else if (!(lo == 1 && hi == 1)) begin
            if (m_dir[k] == 0 && lo == 1) begin
              m_dir[k] = 1; m_edge[k] = 1; m_data[k] = (d << 1) & mask;
            end else if (m_dir[k] == 1 && hi == 1) begin
              m_dir[k] = 0; m_edge[k] = 1; m_data[k] = d >> 1;
            end else if (m_dir[k] == 0) begin
              m_data[k] = d >> 1;
            end else begin
              m_data[k] = (d << 1) & mask;
            end
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    chk("data4", int'(d4), m_data[0]);
    chk("dir4", int'(dir4), m_dir[0]);
    chk("step4", int'(step4), m_step[0]);
    chk("edge4", int'(edge4), m_edge[0]);
    chk("data8", int'(d8), m_data[1]);
    chk("dir8", int'(dir8), m_dir[1]);
    chk("step8", int'(step8), m_step[1]);
    chk("edge8", int'(edge8), m_edge[1]);
  endtask

  task automatic set_in(input logic r, input logic v, input logic [1:0] md,
                        input logic [3:0] dv, input logic ld, input logic [7:0] dt);
    rst = r; valid = v; mode = md; div = dv; load = ld; data8 = dt;
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{8, 4, 2, 1, 8};
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_step[k] = 0; m_edge[k] = 0;
    end

    // Reset values
    set_in(1, 1, 2'd0, 4'd0, 0, 8'h00);
    cycle();
    chk("rst_data4", int'(d4), 1);
    chk("rst_data8", int'(d8), 'h81);

    // Rotate right, step every tick
    set_in(0, 1, 2'd0, 4'd0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("ror_seq4", int'(d4), exp_rr[i]);
    end

    // Rotate left with divide-by-3
    set_in(1, 0, 2'd1, 4'd2, 0, 8'h00);
    cycle();
    set_in(0, 1, 2'd1, 4'd2, 0, 8'h00);
    for (int i = 0; i < 6; i++) cycle();
    chk("rol_div4", int'(d4), 4);
    chk("rol_dir4", int'(dir4), 1);

    // Bounce from 0001 heading right
    set_in(1, 0, 2'd2, 4'd0, 0, 8'h00);
    cycle();
    set_in(0, 1, 2'd2, 4'd0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cycle();
    chk("bounce4", int'(d4), 4);

    // Load wins over a coincident tick
    set_in(0, 1, 2'd0, 4'd1, 1, 8'hAA);
    cycle();
    chk("load4", int'(d4), 'hA);
    chk("load_step4", int'(step4), 0);
    set_in(0, 1, 2'd0, 4'd1, 0, 8'h00);
    cycle();
    cycle();
    chk("load_ror4", int'(d4), 5);

    // Bounce with both ends lit holds, then hold mode freezes
    set_in(0, 0, 2'd2, 4'd0, 1, 8'h99);
    cycle();
    set_in(0, 1, 2'd2, 4'd0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle();
    chk("bounce_ends4", int'(d4), 9);
    set_in(0, 1, 2'd3, 4'd0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-count
    set_in(0, 1, 2'd0, 4'd3, 0, 8'h00);
    cycle();
    cycle();
    set_in(1, 1, 2'd0, 4'd3, 0, 8'h00);
    cycle();
    set_in(0, 1, 2'd0, 4'd3, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_wrap8", int'(d8), 'hC0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 11) == 0);
      valid = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) div = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 15) == 0) div = 4'($urandom_range(0, 2));
      data8 = 8'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
